// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared FSM encoding, button indices and default timing values
package counter_ctrl_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 16;
    localparam int DEF_REPEAT_RATE     = 8;

    localparam int BTN_LOAD = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DOWN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_HOLD,
        S_REPEAT
    } state_e;

endpackage

// File: rtl/debouncer.sv
// debouncer: 2-flop synchronizer followed by a stable-sample counter driving a clean level
module debouncer
    import counter_ctrl_pkg::*;
#(
    parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o
);

    localparam logic [7:0] LAST = 8'(CYCLES - 1);

    logic [1:0] sync_q;
    logic [7:0] cnt_q;
    logic       level_q;

    // synchronize, then accept a new level only after CYCLES consecutive differing samples
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= LAST) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: turns three raw buttons into load / count-enable strobes with auto-repeat
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Btn_load,
    input  logic       Btn_up,
    input  logic       Btn_down,
    input  logic [3:0] Switch_in,
    output logic       Load,
    output logic       Count_en,
    output logic       Up,
    output logic [3:0] Count_in,
    output logic       Busy
);

    localparam logic [7:0] DLY_LAST  = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] RATE_LAST = 8'(REPEAT_RATE - 1);

    logic [2:0] btn, lvl, lvl_q, rise;
    state_e     state_q, state_d;
    logic       load_q, load_d, cen_q, cen_d, up_q, up_d, rpt_q, rpt_d;
    logic [3:0] cin_q, cin_d;
    logic [7:0] tmr_q, tmr_d;
    logic       held, others;

    assign btn = {Btn_down, Btn_up, Btn_load};

    for (genvar g = 0; g < 3; g++) begin : g_deb
        debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk_i  (Clk),
            .rst_ni (nReset),
            .btn_i  (btn[g]),
            .level_o(lvl[g])
        );
    end

    assign rise   = lvl & ~lvl_q;
    assign held   = up_q ? lvl[BTN_UP] : lvl[BTN_DOWN];
    assign others = lvl[BTN_LOAD] | (up_q ? lvl[BTN_DOWN] : lvl[BTN_UP]);

    // next state and registered strobes; rpt_q marks a HOLD entered from a step that may repeat
    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        cen_d   = 1'b0;
        up_d    = up_q;
        cin_d   = cin_q;
        rpt_d   = rpt_q;
        tmr_d   = (tmr_q == 8'hFF) ? tmr_q : tmr_q + 8'd1;
        case (state_q)
            S_IDLE: begin
                if (rise[BTN_LOAD]) begin
                    state_d = S_LOAD;
                    load_d  = 1'b1;
                    cin_d   = Switch_in;
                    rpt_d   = 1'b0;
                end else if (rise[BTN_UP] && rise[BTN_DOWN]) begin
                    state_d = S_HOLD;
                    rpt_d   = 1'b0;
                end else if (rise[BTN_UP] || rise[BTN_DOWN]) begin
                    state_d = S_STEP;
                    cen_d   = 1'b1;
                    up_d    = rise[BTN_UP];
                    rpt_d   = 1'b1;
                    tmr_d   = '0;
                end
            end
            S_LOAD, S_STEP: state_d = S_HOLD;
            S_HOLD: begin
                if (lvl == 3'b000) begin
                    state_d = S_IDLE;
                end else if (!(rpt_q && held && !others)) begin
                    tmr_d = '0;
                end else if (tmr_q >= DLY_LAST) begin
                    state_d = S_REPEAT;
                    cen_d   = 1'b1;
                    tmr_d   = '0;
                end
            end
            S_REPEAT: begin
                if (!held) begin
                    state_d = S_IDLE;
                end else if (tmr_q >= RATE_LAST) begin
                    cen_d = 1'b1;
                    tmr_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state, timer, edge history and output registers
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            cen_q   <= 1'b0;
            up_q    <= 1'b0;
            cin_q   <= '0;
            rpt_q   <= 1'b0;
            tmr_q   <= '0;
            lvl_q   <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            cen_q   <= cen_d;
            up_q    <= up_d;
            cin_q   <= cin_d;
            rpt_q   <= rpt_d;
            tmr_q   <= tmr_d;
            lvl_q   <= lvl;
        end
    end

    assign Load     = load_q;
    assign Count_en = cen_q;
    assign Up       = up_q;
    assign Count_in = cin_q;
    assign Busy     = state_q != S_IDLE;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: scoreboard bench; expected strobes are queued at stimulus time and matched by a monitor
module tb_counter_ctrl;

    localparam int D  = 4;
    localparam int RD = 16;
    localparam int RR = 8;

    typedef struct {
        int         cyc;
        bit         ld;
        bit         up;
        logic [3:0] cin;
    } exp_t;

    logic       Clk = 1'b0;
    logic       nReset = 1'b0;
    logic       Btn_load = 1'b0, Btn_up = 1'b0, Btn_down = 1'b0;
    logic [3:0] Switch_in = 4'b0000;
    logic       Load, Count_en, Up, Busy;
    logic [3:0] Count_in;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n, r;

    counter_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .Btn_load (Btn_load),
        .Btn_up   (Btn_up),
        .Btn_down (Btn_down),
        .Switch_in(Switch_in),
        .Load     (Load),
        .Count_en (Count_en),
        .Up       (Up),
        .Count_in (Count_in),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int k);
        repeat (k) @(negedge Clk);
    endtask

    task automatic push_load(input int start, input logic [3:0] v);
        sb.push_back('{cyc: start + D + 3, ld: 1'b1, up: 1'b0, cin: v});
    endtask

    // step at start+D+3, then repeats while the debounced level is still high the cycle before
    task automatic push_step(input int start, input bit up, input int rel);
        int s;
        s = start + D + 3;
        sb.push_back('{cyc: s, ld: 1'b0, up: up, cin: 4'b0});
        for (int p = s + RD; p <= rel + D + 2; p += RR)
            sb.push_back('{cyc: p, ld: 1'b0, up: up, cin: 4'b0});
    endtask

    task automatic busy_fall(input int rel);
        wait_cyc(rel + D + 2 - cyc);
        chk("busy_before_fall", Busy, 1);
        wait_cyc(1);
        chk("busy_after_fall", Busy, 0);
    endtask

    task automatic drain(input string tag);
        chk(tag, sb.size(), 0);
        chk({tag, "_idle"}, Busy, 0);
        sb.delete();
    endtask

    always @(negedge Clk) begin
        if (Load || Count_en) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", {Load, Count_en}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("strobe_kind", {Load, Count_en}, e.ld ? 2'b10 : 2'b01);
                if (e.ld) chk("count_in", Count_in, e.cin);
                else chk("up", Up, e.up);
            end
        end
    end

    initial begin
        wait_cyc(3);
        chk("rst_load", Load, 0);
        chk("rst_cen", Count_en, 0);
        chk("rst_up", Up, 0);
        chk("rst_cin", Count_in, 0);
        chk("rst_busy", Busy, 0);
        nReset = 1'b1;
        wait_cyc(3);

        Switch_in = 4'b1010;
        n = cyc;
        Btn_load = 1'b1;
        push_load(n, 4'b1010);
        wait_cyc(20);
        Btn_load = 1'b0;
        wait_cyc(20);
        drain("load_drain");

        n = cyc;
        Btn_up = 1'b1;
        push_step(n, 1'b1, n + 10);
        wait_cyc(10);
        Btn_up = 1'b0;
        busy_fall(n + 10);
        wait_cyc(10);
        drain("up_drain");

        n = cyc;
        Btn_down = 1'b1;
        push_step(n, 1'b0, n + 60);
        wait_cyc(60);
        Btn_down = 1'b0;
        busy_fall(n + 60);
        wait_cyc(10);
        drain("down_repeat_drain");

        for (int i = 0; i < 3; i++) begin
            Btn_up = 1'b1;
            wait_cyc(1);
            Btn_up = 1'b0;
            wait_cyc(1);
        end
        n = cyc;
        Btn_up = 1'b1;
        push_step(n, 1'b1, n + 10);
        wait_cyc(10);
        Btn_up = 1'b0;
        wait_cyc(20);
        drain("bounce_drain");

        n = cyc;
        Btn_up = 1'b1;
        Btn_down = 1'b1;
        wait_cyc(D + 4);
        chk("both_steps_busy", Busy, 1);
        wait_cyc(2);
        Btn_up = 1'b0;
        Btn_down = 1'b0;
        wait_cyc(20);
        drain("both_steps_drain");

        Switch_in = 4'b0101;
        n = cyc;
        Btn_load = 1'b1;
        Btn_up = 1'b1;
        push_load(n, 4'b0101);
        wait_cyc(10);
        Btn_load = 1'b0;
        Btn_up = 1'b0;
        wait_cyc(20);
        drain("load_up_drain");

        n = cyc;
        Btn_down = 1'b1;
        push_step(n, 1'b0, n + 34);
        wait_cyc(42);
        #2 nReset = 1'b0;
        #1;
        chk("async_load", Load, 0);
        chk("async_cen", Count_en, 0);
        chk("async_up", Up, 0);
        chk("async_cin", Count_in, 0);
        chk("async_busy", Busy, 0);
        chk("pre_reset_repeats", sb.size(), 0);
        wait_cyc(3);
        r = cyc;
        nReset = 1'b1;
        push_step(r, 1'b0, r + 10);
        wait_cyc(10);
        Btn_down = 1'b0;
        wait_cyc(20);
        drain("post_reset_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
